// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared constants, FSM encoding and shadow-stage record for the ID hazard scoreboard.
// Also holds the register-dependence helpers used by the hazard detector.
package id_hazard_scoreboard_pkg;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MD_START = 2'd1,
        MD_WAIT  = 2'd2
    } md_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};

    // True when an ID source register names the live, non-zero destination of s.
    function automatic logic src_match(input shadow_t s, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic use1, input logic use2);
        return s.valid && (s.rd != ZERO_REG) &&
               ((use1 && (rs1 == s.rd)) || (use2 && (rs2 == s.rd)));
    endfunction

    // A dependent stage blocks ID if its value is not yet forwardable for this consumer:
    // on_load selects "producer is a load", on_write selects "producer writes at all".
    function automatic logic stage_blocks(input shadow_t s, input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic use1, input logic use2,
                                          input logic on_load, input logic on_write);
        return src_match(s, rs1, rs2, use1, use2) &&
               ((on_load && s.mem_read) || (on_write && s.reg_write));
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_shadow_stage.sv
// One shadow pipeline register of the hazard scoreboard (used for EX and MEM).
// hold keeps the contents, bubble inserts an empty slot, otherwise load_val is captured.
module hazard_shadow_stage
    import id_hazard_scoreboard_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    hold,
    input  logic    bubble,
    input  shadow_t load_val,
    output shadow_t q
);

    // Shadow register with hold priority over bubble over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SHADOW_EMPTY;
        end else if (hold) begin
            q <= q;
        end else if (bubble) begin
            q <= SHADOW_EMPTY;
        end else begin
            q <= load_val;
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard: detects hazards forwarding cannot cover, drives
// stall/bubble/freeze, sequences the mul/div handshake and counts stall cycles.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_id,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic [4:0]        rd_id,
    input  logic              reg_write_id,
    input  logic              mem_read_id,
    input  logic              branch_id,
    input  logic              jalr_id,
    input  logic              md_id,
    input  logic              flush_id,
    input  logic              md_done,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              freeze,
    output logic              md_start,
    output logic [PERF_W-1:0] stall_cnt
);

    shadow_t   ex_r;
    shadow_t   mem_r;
    shadow_t   id_entry_s;
    md_state_t state_r;
    md_state_t state_next_s;

    logic live_s;
    logic ctrl_s;
    logic use_rs2_eff_s;
    logic hazard_s;
    logic launch_s;
    logic freeze_s;
    logic md_start_s;
    logic stall_s;

    // jalr has no rs2 operand, so its rs2 field never creates a dependence.
    assign live_s        = valid_id && !flush_id;
    assign ctrl_s        = branch_id || jalr_id;
    assign use_rs2_eff_s = use_rs2_id && !jalr_id;

    // EX term covers load-use and branch-on-EX; MEM term covers branch-on-load-in-MEM.
    assign hazard_s = live_s &&
        (stage_blocks(ex_r,  rs1_id, rs2_id, use_rs1_id, use_rs2_eff_s, 1'b1,   ctrl_s) ||
         stage_blocks(mem_r, rs1_id, rs2_id, use_rs1_id, use_rs2_eff_s, ctrl_s, 1'b0));

    assign launch_s   = valid_id && md_id && !hazard_s && !flush_id;
    assign id_entry_s = '{valid: 1'b1, rd: rd_id, reg_write: reg_write_id, mem_read: mem_read_id};

    hazard_shadow_stage u_ex_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (freeze_s),
        .bubble   (hazard_s || flush_id || !valid_id),
        .load_val (id_entry_s),
        .q        (ex_r)
    );

    hazard_shadow_stage u_mem_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (freeze_s),
        .bubble   (1'b0),
        .load_val (ex_r),
        .q        (mem_r)
    );

    // Mul/div sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Mul/div sequencer next state and freeze/start controls.
    always_comb begin
        state_next_s = state_r;
        freeze_s     = 1'b0;
        md_start_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_next_s = MD_START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MD_START: begin
                md_start_s   = 1'b1;
                freeze_s     = 1'b1;
                state_next_s = MD_WAIT;
            end
            MD_WAIT: begin
                // The done cycle already behaves as IDLE, so a queued md op launches without a gap.
                if (md_done) begin
                    freeze_s     = 1'b0;
                    state_next_s = launch_s ? MD_START : IDLE;
                end else begin
                    freeze_s     = 1'b1;
                    state_next_s = MD_WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign stall_s     = hazard_s || freeze_s;
    assign stall_pc    = stall_s;
    assign stall_ifid  = stall_s;
    assign bubble_idex = (hazard_s || flush_id) && !freeze_s;
    assign freeze      = freeze_s;
    assign md_start    = md_start_s;

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= {PERF_W{1'b0}};
        end else if (stall_s && (stall_cnt != {PERF_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Scoreboard bench for id_hazard_scoreboard: directed scenarios plus random traffic
// against an instruction-level reference model; a negedge monitor checks every cycle.
module tb_id_hazard_scoreboard;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1, u2, w, ld, br, jr, md, fl;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        frz;
        logic        start;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       w;
        bit       ld;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic valid_id, use_rs1_id, use_rs2_id, reg_write_id, mem_read_id;
    logic branch_id, jalr_id, md_id, flush_id, md_done;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic stall_pc, stall_ifid, bubble_idex, freeze, md_start;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    int md_start_seen = 0;
    exp_t exp_q[$];

    // reference model state: instructions in flight, mul/div progress, stall total
    ent_t m_ex, m_mem;
    int   m_busy;       // 0 free, 1 start cycle, 2 waiting for result
    int   m_cnt;
    bit   last_stall;
    int   md_timer = -1;
    int   md_lat = 4;
    bit   auto_done = 1'b1;
    bit   spurious = 1'b0;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.PERF_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_id(rd_id),
        .reg_write_id(reg_write_id), .mem_read_id(mem_read_id), .branch_id(branch_id),
        .jalr_id(jalr_id), .md_id(md_id), .flush_id(flush_id), .md_done(md_done),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
        .freeze(freeze), .md_start(md_start), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: every cycle the DUT presents outputs, compare against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_pc",    {31'd0, stall_pc},    {31'd0, e.stall});
            chk("stall_ifid",  {31'd0, stall_ifid},  {31'd0, e.stall});
            chk("bubble_idex", {31'd0, bubble_idex}, {31'd0, e.bubble});
            chk("freeze",      {31'd0, freeze},      {31'd0, e.frz});
            chk("md_start",    {31'd0, md_start},    {31'd0, e.start});
            chk("stall_cnt",   {16'd0, stall_cnt},   {16'd0, e.cnt});
            if (md_start) md_start_seen++;
        end
    end

    function automatic in_t mk(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic w, input logic ld,
                               input logic br, input logic jr, input logic md);
        in_t t;
        t.valid = v; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.u1 = u1; t.u2 = u2; t.w = w; t.ld = ld; t.br = br; t.jr = jr; t.md = md; t.fl = 1'b0;
        return t;
    endfunction

    function automatic in_t nop();
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic in_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return mk(1'b1, rd, a, b, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic in_t lw(input logic [4:0] rd, input logic [4:0] a);
        return mk(1'b1, rd, a, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic in_t beq(input logic [4:0] a, input logic [4:0] b);
        return mk(1'b1, 5'd0, a, b, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic in_t jalr(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] bfield);
        return mk(1'b1, rd, a, bfield, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic in_t mul(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return mk(1'b1, rd, a, b, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction
    function automatic in_t flushed(input in_t i);
        in_t t;
        t = i;
        t.fl = 1'b1;
        return t;
    endfunction

    // does instruction i consume register r (x0 never counts, jalr has no rs2)
    function automatic bit reads(input in_t i, input bit [4:0] r);
        return (r != 5'd0) && ((i.u1 && i.rs1 == r) || (i.u2 && !i.jr && i.rs2 == r));
    endfunction

    task automatic model_reset();
        m_ex = '{v: 1'b0, rd: 5'd0, w: 1'b0, ld: 1'b0};
        m_mem = m_ex;
        m_busy = 0;
        m_cnt = 0;
        md_timer = -1;
        last_stall = 1'b0;
    endtask

    // one pipeline cycle: drive ID, predict outputs, push expectation, advance the model
    task automatic step(input in_t i);
        exp_t e;
        bit d, live, ctrl, hz, frz;
        if (md_timer > 0) md_timer--;
        d = (md_timer == 0) || (md_timer < 0 && spurious && ($urandom % 8 == 0));
        if (md_timer == 0) md_timer = -1;
        valid_id = i.valid; rs1_id = i.rs1; rs2_id = i.rs2; use_rs1_id = i.u1; use_rs2_id = i.u2;
        rd_id = i.rd; reg_write_id = i.w; mem_read_id = i.ld; branch_id = i.br; jalr_id = i.jr;
        md_id = i.md; flush_id = i.fl; md_done = d;
        live = i.valid && !i.fl;
        ctrl = i.br || i.jr;
        // a load result is only forwardable from WB; a branch needs operands in ID
        hz = live && ((m_ex.v && reads(i, m_ex.rd) && (m_ex.ld || (ctrl && m_ex.w))) ||
                      (ctrl && m_mem.v && m_mem.ld && reads(i, m_mem.rd)));
        frz = (m_busy == 1) || (m_busy == 2 && !d);
        e.stall = hz || frz;
        e.bubble = (hz || i.fl) && !frz;
        e.frz = frz;
        e.start = (m_busy == 1);
        e.cnt = m_cnt[15:0];
        exp_q.push_back(e);
        last_stall = e.stall;
        if (e.start && auto_done) md_timer = md_lat;
        if (e.stall && m_cnt != 65535) m_cnt++;
        if (m_busy == 1) m_busy = 2;
        else if (!frz) m_busy = (live && i.md && !hz) ? 1 : 0;
        if (!frz) begin
            m_mem = m_ex;
            if (hz || i.fl || !i.valid) m_ex = '{v: 1'b0, rd: 5'd0, w: 1'b0, ld: 1'b0};
            else m_ex = '{v: 1'b1, rd: i.rd, w: i.w, ld: i.ld};
        end
        @(posedge clk);
        #1;
    endtask

    // present an instruction until the pipeline accepts it, with a cycle budget
    task automatic issue(input in_t i);
        int n;
        n = 0;
        do begin
            step(i);
            n++;
        end while (last_stall && n < 40);
        chk("issue_budget", {31'd0, last_stall}, 32'd0);
    endtask

    function automatic in_t rand_instr();
        logic [4:0] a, b, r;
        int k;
        a = 5'($urandom % 8); b = 5'($urandom % 8); r = 5'($urandom % 8);
        k = $urandom % 8;
        case (k)
            0: return nop();
            3: return lw(r, a);
            4: return beq(a, b);
            5: return jalr(r, a, b);
            6: return ($urandom % 2 == 0) ? mul(r, a, b) : alu(r, a, b);
            default: return alu(r, a, b);
        endcase
    endfunction

    initial begin
        int base;
        in_t cur;
        rst_n = 1'b0;
        valid_id = 1'b0; rs1_id = 5'd0; rs2_id = 5'd0; use_rs1_id = 1'b0; use_rs2_id = 1'b0;
        rd_id = 5'd0; reg_write_id = 1'b0; mem_read_id = 1'b0; branch_id = 1'b0; jalr_id = 1'b0;
        md_id = 1'b0; flush_id = 1'b0; md_done = 1'b0;
        model_reset();
        #12;
        chk("reset_stall_pc", {31'd0, stall_pc}, 32'd0);
        chk("reset_bubble",   {31'd0, bubble_idex}, 32'd0);
        chk("reset_freeze",   {31'd0, freeze}, 32'd0);
        chk("reset_md_start", {31'd0, md_start}, 32'd0);
        chk("reset_cnt",      {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(lw(5'd5, 5'd1)); issue(alu(5'd6, 5'd5, 5'd1));
        chk("cnt_load_use", {16'd0, stall_cnt}, 32'd1);
        issue(nop()); issue(nop());
        issue(alu(5'd5, 5'd1, 5'd2)); issue(beq(5'd5, 5'd0));
        chk("cnt_alu_branch", {16'd0, stall_cnt}, 32'd2);
        issue(nop()); issue(nop());
        issue(lw(5'd5, 5'd1)); issue(beq(5'd5, 5'd0));
        chk("cnt_load_branch", {16'd0, stall_cnt}, 32'd4);
        issue(nop()); issue(nop());
        issue(lw(5'd0, 5'd1)); issue(alu(5'd1, 5'd0, 5'd0));
        issue(lw(5'd5, 5'd1)); issue(jalr(5'd1, 5'd2, 5'd5));
        chk("cnt_zero_jalr", {16'd0, stall_cnt}, 32'd4);
        issue(nop()); issue(nop());

        issue(lw(5'd5, 5'd1)); step(flushed(alu(5'd6, 5'd5, 5'd1))); issue(nop());
        base = md_start_seen;
        issue(mul(5'd7, 5'd1, 5'd2)); issue(nop());
        chk("cnt_mul", {16'd0, stall_cnt}, 32'd8);
        chk("md_start_pulses", md_start_seen - base, 32'd1);
        issue(mul(5'd7, 5'd1, 5'd2)); issue(flushed(alu(5'd3, 5'd1, 5'd2))); issue(nop());
        issue(mul(5'd7, 5'd1, 5'd2)); issue(mul(5'd8, 5'd3, 5'd4)); issue(nop()); issue(nop());

        spurious = 1'b1;
        cur = nop();
        for (int n = 0; n < 3000; n++) begin
            md_lat = $urandom_range(1, 6);
            if (!last_stall) cur = rand_instr();
            cur.fl = ($urandom % 10 == 0);
            step(cur);
        end
        spurious = 1'b0;
        md_lat = 4;
        issue(nop()); issue(nop()); issue(nop());

        auto_done = 1'b0;
        step(mul(5'd7, 5'd1, 5'd2));
        for (int n = 0; n < 65540; n++) step(nop());
        chk("cnt_saturated", {16'd0, stall_cnt}, 32'h0000ffff);
        chk("freeze_before_rst", {31'd0, freeze}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_freeze",   {31'd0, freeze}, 32'd0);
        chk("rst_md_start", {31'd0, md_start}, 32'd0);
        chk("rst_stall_pc", {31'd0, stall_pc}, 32'd0);
        chk("rst_cnt",      {16'd0, stall_cnt}, 32'd0);
        model_reset();
        auto_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(lw(5'd5, 5'd1)); issue(alu(5'd6, 5'd5, 5'd1));
        chk("cnt_after_rst", {16'd0, stall_cnt}, 32'd1);
        issue(mul(5'd9, 5'd1, 5'd2)); issue(nop());
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
